// File: rtl/blockmem_rd_arb.sv
// ---------------------------------------------------------------------------
// blockmem_rd_arb
//
// Round-robin arbiter that shares the read port of a 2-port block memory
// (registered read, one cycle of latency) between G_NUM_REQ requesters.
// Each requester gets a valid/ready request channel and a one-entry
// registered response channel. One instance sits in front of each memory,
// between the AXI read-side engines and the memory read port.
//
// Arbitration is combinational: the grant, mem_enb and mem_addrb all follow
// the request inputs in the same cycle. The read data is captured into the
// granted requester's response register on the edge after the memory read,
// so a request accepted in cycle T shows rsp_valid in cycle T+2.
//
// Ports
//   clk        clock for all logic and for the memory read port
//   rst        asynchronous, active-high reset
//   req_valid  per-requester read request
//   req_addr   packed word addresses, requester i at [i*AW +: AW]
//   req_ready  one-hot (or zero) grant; request accepted on valid & ready
//   rsp_valid  per-requester read data valid
//   rsp_data   packed read data, requester i at [i*DW +: DW]
//   rsp_ready  per-requester response accept
//   mem_enb    memory read enable
//   mem_addrb  memory read address
//   mem_doutb  memory read data, valid the cycle after mem_enb
// ---------------------------------------------------------------------------
module blockmem_rd_arb #(
    parameter  int G_MEMWIDTH  = 32,
    parameter  int G_MEMDEPTH  = 1024,
    parameter  int G_NUM_REQ   = 2,
    localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
    localparam int G_IDXWIDTH  = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [G_NUM_REQ-1:0]              req_valid,
    input  logic [G_NUM_REQ*G_ADDRWIDTH-1:0]  req_addr,
    output logic [G_NUM_REQ-1:0]              req_ready,
    output logic [G_NUM_REQ-1:0]              rsp_valid,
    output logic [G_NUM_REQ*G_MEMWIDTH-1:0]   rsp_data,
    input  logic [G_NUM_REQ-1:0]              rsp_ready,
    output logic                              mem_enb,
    output logic [G_ADDRWIDTH-1:0]            mem_addrb,
    input  logic [G_MEMWIDTH-1:0]             mem_doutb
);

    // Eligibility vector padded to a power of two so that it can be indexed
    // by a full G_IDXWIDTH-bit value without out-of-range selects.
    localparam int PAD_W = 1 << G_IDXWIDTH;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [G_NUM_REQ-1:0]                 inflight_q, inflight_d;
    logic [G_NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
    logic [G_NUM_REQ-1:0][G_MEMWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [G_IDXWIDTH-1:0]                rr_ptr_q, rr_ptr_d;

    // -----------------------------------------------------------------------
    // Arbitration signals
    // -----------------------------------------------------------------------
    logic [G_NUM_REQ-1:0]  eligible;
    logic [PAD_W-1:0]      elig_pad;
    logic                  grant_any;
    logic                  grant_ok;
    logic [G_IDXWIDTH-1:0] grant_idx;
    logic [G_IDXWIDTH-1:0] cand_idx;

    // A requester may be granted only when it has no read in flight and its
    // response slot is free or is being emptied this very cycle. A stalled
    // response therefore only removes its own requester from the rotation.
    for (genvar gi = 0; gi < G_NUM_REQ; gi++) begin : g_elig
        assign eligible[gi] = req_valid[gi] & ~inflight_q[gi]
                            & (~rsp_valid_q[gi] | rsp_ready[gi]);
    end

    assign elig_pad = PAD_W'(eligible);

    // Round-robin search: start just after the last granted requester and
    // wrap; the first eligible one wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = 1; k <= G_NUM_REQ; k++) begin
            cand_idx = G_IDXWIDTH'((int'(rr_ptr_q) + k) % G_NUM_REQ);
            if (!grant_any && elig_pad[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // No grant may escape while reset is asserted, even though the search
    // itself is purely combinational.
    assign grant_ok = grant_any & ~rst;

    for (genvar gi = 0; gi < G_NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = grant_ok & (grant_idx == G_IDXWIDTH'(gi));
    end

    // -----------------------------------------------------------------------
    // Memory read port
    // -----------------------------------------------------------------------
    assign mem_enb = grant_ok;

    // req_ready is one-hot or zero, so an OR-of-selected mux is sufficient and
    // yields address zero when idle.
    always_comb begin
        mem_addrb = '0;
        for (int i = 0; i < G_NUM_REQ; i++) begin
            if (req_ready[i]) begin
                mem_addrb = req_addr[i*G_ADDRWIDTH +: G_ADDRWIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // The grant vector is exactly the set of reads launched this cycle.
    assign inflight_d = req_ready;

    assign rr_ptr_d = grant_ok ? grant_idx : rr_ptr_q;

    // A capture and a consume on the same edge resolve in favour of the
    // capture: the new data replaces the consumed word and stays valid.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < G_NUM_REQ; i++) begin
            if (inflight_q[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = mem_doutb;
            end else if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // rr_ptr resets to the last index so that requester 0 is searched first.
    // Reset also discards any read in flight; its data is never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rr_ptr_q    <= G_IDXWIDTH'(G_NUM_REQ - 1);
        end else begin
            inflight_q  <= inflight_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_blockmem_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_blockmem_rd_arb
//
// Directed bench for blockmem_rd_arb. A two-requester instance is checked
// every cycle against a transaction-level model (who may be granted, which
// responses are held and what data they carry), and a three-requester
// instance is used for the rotation-order case. Hand-computed literal values
// pin the model at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_blockmem_rd_arb;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Two-requester instance
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] rsp_data;
    logic            mem_enb;
    logic [AW-1:0]   mem_addrb;
    logic [DW-1:0]   mem_doutb = '0;

    // Three-requester instance
    logic [2:0]      r3_valid, r3_ready, r3_rvalid, r3_rready;
    logic [3*AW-1:0] r3_addr;
    logic [3*DW-1:0] r3_rdata;
    logic            m3_enb;
    logic [AW-1:0]   m3_addrb;
    logic [DW-1:0]   m3_dout = '0;

    blockmem_rd_arb #(.G_MEMWIDTH(DW), .G_MEMDEPTH(1024), .G_NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
    );

    blockmem_rd_arb #(.G_MEMWIDTH(DW), .G_MEMDEPTH(1024), .G_NUM_REQ(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(r3_valid), .req_addr(r3_addr), .req_ready(r3_ready),
        .rsp_valid(r3_rvalid), .rsp_data(r3_rdata), .rsp_ready(r3_rready),
        .mem_enb(m3_enb), .mem_addrb(m3_addrb), .mem_doutb(m3_dout)
    );

    // Preloaded memory content: mem[a] = A5A5_0000 | a
    function automatic logic [31:0] memval(input int a);
        return 32'hA5A5_0000 | 32'(a);
    endfunction

    // Registered-read memories
    always @(posedge clk) begin
        if (mem_enb) mem_doutb <= memval(int'(mem_addrb));
        if (m3_enb)  m3_dout   <= memval(int'(m3_addrb));
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Transaction model of the two-requester instance
    // m_pend : a read for this requester was launched last cycle
    // m_rv/rd: the response slot as the requester sees it
    // m_last : last requester served, reset to N-1 so requester 0 goes first
    // -----------------------------------------------------------------------
    bit          m_pend [N] = '{default: 1'b0};
    int          m_paddr[N] = '{default: 0};
    bit          m_rv   [N] = '{default: 1'b0};
    logic [31:0] m_rd   [N] = '{default: 32'h0};
    int          m_last     = N - 1;

    always @(negedge clk) begin
        int g;
        int j;
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] exp_addr;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_rv[i]   = 1'b0;
                m_rd[i]   = 32'h0;
            end
            m_last = N - 1;
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_mem_enb",   64'(mem_enb),   64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_rsp_data",  64'(rsp_data),  64'(0));
        end else begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (g < 0 && req_valid[j] && !m_pend[j] && (!m_rv[j] || rsp_ready[j]))
                    g = j;
            end
            exp_rdy  = '0;
            exp_addr = '0;
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                exp_addr   = req_addr[g*AW +: AW];
            end
            chk("model_req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("model_mem_enb",   64'(mem_enb),   64'(g >= 0));
            chk("model_mem_addrb", 64'(mem_addrb), 64'(exp_addr));
            chk("model_rsp_valid", 64'(rsp_valid), 64'({m_rv[1], m_rv[0]}));
            chk("model_rsp_data",  64'(rsp_data),  {m_rd[1], m_rd[0]});
            // advance the model across the coming clock edge
            for (int i = 0; i < N; i++) begin
                if (m_pend[i]) begin
                    m_rv[i] = 1'b1;
                    m_rd[i] = memval(m_paddr[i]);
                end else if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i] = 1'b0;
                end
                m_pend[i] = (g == i);
                if (g == i) m_paddr[i] = int'(req_addr[i*AW +: AW]);
            end
            if (g >= 0) m_last = g;
        end
    end

    // Response collector for the streaming scenario
    bit          collect = 1'b0;
    logic [31:0] rq[$];

    always @(negedge clk) begin
        if (collect && !rst && rsp_valid[0] && rsp_ready[0]) rq.push_back(rsp_data[31:0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Directed stimulus
    // -----------------------------------------------------------------------
    initial begin
        logic [1:0] exp2[4];
        logic [1:0] exp3[7];
        logic [2:0] exp5[4];
        int acc[$];
        int n;
        bit got;

        exp2 = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp3 = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01};
        exp5 = '{3'b001, 3'b010, 3'b100, 3'b001};

        req_valid = '0; req_addr = '0; rsp_ready = 2'b11;
        r3_valid  = '0; r3_addr  = {10'd3, 10'd2, 10'd1}; r3_rready = 3'b111;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: single read
        req_valid = 2'b01; req_addr[9:0] = 10'd5;
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'(2'b01));
        chk("t1_mem_enb",   64'(mem_enb),   64'(1));
        chk("t1_mem_addrb", 64'(mem_addrb), 64'(5));
        step(); req_valid = 2'b00;
        @(negedge clk);
        chk("t1_rsp_early", 64'(rsp_valid[0]), 64'(0));
        step();
        @(negedge clk);
        chk("t1_rsp_valid", 64'(rsp_valid[0]),   64'(1));
        chk("t1_rsp_data",  64'(rsp_data[31:0]), 64'(32'hA5A5_0005));
        repeat (3) step();

        // 2: contention from reset release
        rst = 1'b1;
        req_addr = {10'd32, 10'd16}; req_valid = 2'b11;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t2_grant",   64'(req_ready), 64'(exp2[c]));
            chk("t2_mem_enb", 64'(mem_enb),   64'(1));
            step();
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("t2_rsp_order", 64'(rsp_valid),       64'(2'b01));
        chk("t2_rsp_data",  64'(rsp_data[31:0]),  64'(32'hA5A5_0010));
        repeat (3) step();

        // 3: backpressure on requester 0
        rsp_ready = 2'b10; req_addr = {10'd41, 10'd40}; req_valid = 2'b11;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) rsp_ready = 2'b11;
            @(negedge clk);
            chk("t3_grant", 64'(req_ready), 64'(exp3[c]));
            if (c >= 2 && c <= 5) begin
                chk("t3_hold_valid", 64'(rsp_valid[0]),   64'(1));
                chk("t3_hold_data",  64'(rsp_data[31:0]), 64'(32'hA5A5_0028));
            end
            step();
        end
        req_valid = 2'b00;
        repeat (3) step();

        // 4: streaming single requester, addresses 0..7
        rq.delete(); collect = 1'b1;
        n = 0; req_addr[9:0] = 10'd0; req_valid = 2'b01;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            @(negedge clk);
            got = req_ready[0];
            if (got) acc.push_back(cyc);
            step();
            if (got) begin
                n++;
                req_addr[9:0] = 10'(n);
                if (n == 8) req_valid = 2'b00;
            end
        end
        repeat (4) step();
        collect = 1'b0;
        chk("t4_accepts",   64'(n),         64'(8));
        chk("t4_rsp_count", 64'(rq.size()), 64'(8));
        for (int k = 0; k < 8 && k < rq.size(); k++)
            chk("t4_rsp_data", 64'(rq[k]), 64'(memval(k)));
        for (int k = 1; k < acc.size(); k++)
            chk("t4_accept_gap", 64'(acc[k] - acc[k-1]), 64'(2));

        // 5: top address, then three-way rotation
        req_valid = 2'b10; req_addr[19:10] = 10'd1023;
        @(negedge clk);
        chk("t5_req_ready", 64'(req_ready), 64'(2'b10));
        chk("t5_mem_addrb", 64'(mem_addrb), 64'(1023));
        step(); req_valid = 2'b00;
        step();
        @(negedge clk);
        chk("t5_rsp_valid", 64'(rsp_valid[1]),    64'(1));
        chk("t5_rsp_data",  64'(rsp_data[63:32]), 64'(32'hA5A5_03FF));
        step();
        r3_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_rot_grant",   64'(r3_ready), 64'(exp5[c]));
            chk("t5_rot_mem_enb", 64'(m3_enb),   64'(1));
            step();
        end
        r3_valid = 3'b000;
        repeat (3) step();

        // 6: reset the cycle after a grant
        req_valid = 2'b01; req_addr[9:0] = 10'd7;
        @(negedge clk);
        chk("t6_grant", 64'(req_ready), 64'(2'b01));
        step();
        rst = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        chk("t6_rsp_cleared", 64'(rsp_valid), 64'(0));
        chk("t6_enb_in_rst",  64'(mem_enb),   64'(0));
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_no_stale_rsp", 64'(rsp_valid), 64'(0));
            step();
        end
        req_valid = 2'b11;
        @(negedge clk);
        chk("t6_first_grant", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = 2'b00;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
